// File: rtl/csa_wide_add_seq_pkg.sv
// Shared definitions for the wide add sequencer: slice width, FSM state
// encoding and the legal range of the WORDS parameter.
package csa_wide_add_seq_pkg;

  // Width of one operand slice handled by the shared adder per cycle.
  localparam int WORD_W = 16;

  // Legal range for the number of slices.
  localparam int WORDS_MIN = 1;
  localparam int WORDS_MAX = 16;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index width: clog2(words) but never less than one bit.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/csa_wide_add_seq_csa16.sv
// 16-bit carry-select adder used as the single slice adder of the sequencer.
// Four 4-bit blocks each precompute the sum for carry-in 0 and 1; the real
// block carry then selects one of the two results.
module Carry_Select_Adder_16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  localparam int BLK_W = 4;
  localparam int N_BLK = 4;

  // Carry entering each block; the last entry is the adder carry out.
  logic [N_BLK:0] w_blk_c;

  assign w_blk_c[0] = cin;

  for (genvar g = 0; g < N_BLK; g++) begin : g_blk
    logic [BLK_W:0] w_s0;
    logic [BLK_W:0] w_s1;

    // Both candidate results are formed before the block carry is known.
    assign w_s0 = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]};
    assign w_s1 = {1'b0, a[g*BLK_W +: BLK_W]} + {1'b0, b[g*BLK_W +: BLK_W]}
                + {{BLK_W{1'b0}}, 1'b1};

    assign sum[g*BLK_W +: BLK_W] = w_blk_c[g] ? w_s1[BLK_W-1:0] : w_s0[BLK_W-1:0];
    assign w_blk_c[g+1]          = w_blk_c[g] ? w_s1[BLK_W]     : w_s0[BLK_W];
  end

  assign cout = w_blk_c[N_BLK];

endmodule

// File: rtl/csa_wide_add_seq.sv
// Wide adder that reuses one 16-bit carry-select adder over WORDS cycles,
// lowest slice first, with the carry chained through a register.
// Optional feature macro: CSA_SEQ_SUB_EN adds the sub port (a - b mode).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the sender holds valid and data stable until that edge, and the
// receiver may assert ready independently of valid.
module csa_wide_add_seq
  import csa_wide_add_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  input  logic                    cin,
`ifdef CSA_SEQ_SUB_EN
  input  logic                    sub,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                    cout,
  output logic                    busy,
  output state_t                  o_dbg_state
);

  localparam int                 OP_W     = WORD_W * WORDS;
  localparam int                 IDX_W    = idx_width(WORDS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORDS - 1);

  if (WORDS < WORDS_MIN || WORDS > WORDS_MAX) begin : g_bad_words
    $error("csa_wide_add_seq: WORDS out of legal range");
  end

  state_t             r_state;
  state_t             w_state_nxt;

  logic [OP_W-1:0]    r_op_a;
  logic [OP_W-1:0]    r_op_b;
  logic [WORD_W-1:0]  r_sum_words [WORDS];
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cout;
  logic               r_busy;

  logic [WORD_W-1:0]  w_a_words [WORDS];
  logic [WORD_W-1:0]  w_b_words [WORDS];
  logic [WORD_W-1:0]  w_add_a;
  logic [WORD_W-1:0]  w_add_b;
  logic [WORD_W-1:0]  w_add_sum;
  logic               w_add_cout;

  logic               w_accept;
  logic               w_last;
  logic               w_release;
  logic               w_init_carry;

  // Split captured operands into slices and gather result slices into sum.
  for (genvar g = 0; g < WORDS; g++) begin : g_slices
    assign w_a_words[g]              = r_op_a[g*WORD_W +: WORD_W];
    assign w_b_words[g]              = r_op_b[g*WORD_W +: WORD_W];
    assign sum[g*WORD_W +: WORD_W]   = r_sum_words[g];
  end

  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_state == RUN) && (r_idx == LAST_IDX);
  assign w_release = out_valid && out_ready;

  assign w_add_a   = w_a_words[r_idx];

`ifdef CSA_SEQ_SUB_EN
  logic r_sub;

  // Subtraction is a + ~b + 1: invert B slices and seed the chain with 1.
  assign w_init_carry = sub ? 1'b1 : cin;
  assign w_add_b      = r_sub ? ~w_b_words[r_idx] : w_b_words[r_idx];

  // Mode bit is captured together with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= sub;
    end
  end
`else
  assign w_init_carry = cin;
  assign w_add_b      = w_b_words[r_idx];
`endif

  Carry_Select_Adder_16bits u_slice_adder (
    .a    (w_add_a),
    .b    (w_add_b),
    .cin  (r_carry),
    .sum  (w_add_sum),
    .cout (w_add_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: accept in IDLE, leave RUN after the top slice,
  // leave DONE on the result handshake.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (w_release) w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, carry chain and slice index; idx holds at the top
  // slice instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (w_accept) begin
      r_op_a  <= a;
      r_op_b  <= b;
      r_idx   <= '0;
      r_carry <= w_init_carry;
      r_busy  <= 1'b1;
    end else if (r_state == RUN) begin
      r_carry <= w_add_cout;
      if (w_last) begin
        r_cout <= w_add_cout;
      end else begin
        r_idx  <= r_idx + 1'b1;
      end
    end else if (w_release) begin
      r_busy  <= 1'b0;
    end
  end

  // Result slices: written one per RUN cycle, otherwise held (also in IDLE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        r_sum_words[i] <= '0;
      end
    end else if (r_state == RUN) begin
      r_sum_words[r_idx] <= w_add_sum;
    end
  end

  assign cout        = r_cout;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_csa_wide_add_seq.sv
// Directed testbench for csa_wide_add_seq (WORDS=4). Expected values are
// hand-computed constants; define CSA_SEQ_SUB_EN to add the subtract vectors.
module tb_csa_wide_add_seq;
  import csa_wide_add_seq_pkg::*;

  localparam int WORDS = 4;
  localparam int OP_W  = 16 * WORDS;

  logic            clk       = 1'b0;
  logic            rst_n     = 1'b0;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [OP_W-1:0] a         = '0;
  logic [OP_W-1:0] b         = '0;
  logic            cin       = 1'b0;
`ifdef CSA_SEQ_SUB_EN
  logic            sub       = 1'b0;
`endif
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [OP_W-1:0] sum;
  logic            cout;
  logic            busy;
  state_t          dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Scoreboard for the back-to-back run: {cout, sum} per accepted op.
  logic [OP_W:0] exp_q[$];

  csa_wide_add_seq #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
`ifdef CSA_SEQ_SUB_EN
    .sub         (sub),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [OP_W:0] obs, input logic [OP_W:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (at negedges) for in_ready, bounded.
  task automatic wait_in_ready(input string tag);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_ready"}, 65'(in_ready), 65'(1));
  endtask

  // Offer an operand set; returns at the negedge after the accept edge.
  task automatic offer(input string tag, input logic [OP_W-1:0] va,
                       input logic [OP_W-1:0] vb, input logic vc);
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    wait_in_ready(tag);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count negedges until out_valid, bounded.
  task automatic wait_out_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Complete the result handshake.
  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int lat;
  int t_acc[3];
  int got;

  initial begin
    // Reset values while rst_n is held low.
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready",  65'(in_ready),  65'(1));
    check_eq("rst_out_valid", 65'(out_valid), 65'(0));
    check_eq("rst_busy",      65'(busy),      65'(0));
    check_eq("rst_sum",       65'(sum),       65'(0));
    check_eq("rst_cout",      65'(cout),      65'(0));
    check_eq("rst_state",     65'(dbg_state), 65'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // T1: all-ones + 1 ripples through every slice; latency 4.
    offer("t1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    a = 64'h5555_5555_5555_5555;  // changes after capture must not matter
    b = 64'h3333_3333_3333_3333;
    check_eq("t1_ov_early", 65'(out_valid), 65'(0));
    check_eq("t1_busy",     65'(busy),      65'(1));
    check_eq("t1_state",    65'(dbg_state), 65'(RUN));
    wait_out_valid(lat);
    check_eq("t1_latency",  65'(lat),       65'(4));
    check_eq("t1_sum",      65'(sum),       65'(0));
    check_eq("t1_cout",     65'(cout),      65'(1));
    check_eq("t1_in_ready", 65'(in_ready),  65'(0));
    take_result();
    check_eq("t1_idle_ready", 65'(in_ready),  65'(1));
    check_eq("t1_idle_ov",    65'(out_valid), 65'(0));
    check_eq("t1_idle_busy",  65'(busy),      65'(0));

    // T2: carry from word 0 into word 1 with cin=1.
    offer("t2", 64'h0000_0000_0000_FCFF, 64'h0000_0000_0000_FFF0, 1'b1);
    cin = 1'b0;
    wait_out_valid(lat);
    check_eq("t2_sum",  65'(sum),  65'h0_0000_0000_0001_FCF0);
    check_eq("t2_cout", 65'(cout), 65'(0));
    take_result();

    // T3: backpressure in DONE with new operands already offered.
    offer("t3", 64'h1234, 64'h1111, 1'b0);
    wait_out_valid(lat);
    a        = 64'h10;
    b        = 64'h20;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_hold_ov",    65'(out_valid), 65'(1));
      check_eq("t3_hold_ready", 65'(in_ready),  65'(0));
      check_eq("t3_hold_sum",   65'(sum),       65'h2345);
      check_eq("t3_hold_cout",  65'(cout),      65'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("t3_rel_ready", 65'(in_ready),  65'(1));
    check_eq("t3_rel_ov",    65'(out_valid), 65'(0));
    check_eq("t3_rel_sum",   65'(sum),       65'h2345);
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid(lat);
    check_eq("t3_new_sum", 65'(sum), 65'h30);
    take_result();

    // T4: reset after two RUN edges aborts and clears the partial sum.
    offer("t4", 64'h0001_0002_0003_0004, 64'h0001_0001_0001_0001, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("t4_partial", 65'(sum), 65'h0_0000_0000_0004_0005);
    rst_n = 1'b0;
    #1;
    check_eq("t4_rst_ov",    65'(out_valid), 65'(0));
    check_eq("t4_rst_sum",   65'(sum),       65'(0));
    check_eq("t4_rst_ready", 65'(in_ready),  65'(1));
    check_eq("t4_rst_busy",  65'(busy),      65'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    offer("t4b", 64'h1, 64'h2, 1'b0);
    wait_out_valid(lat);
    check_eq("t4_after_sum",  65'(sum),  65'h3);
    check_eq("t4_after_cout", 65'(cout), 65'(0));
    take_result();

    // T5: back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    got = 0;
    fork
      begin
        logic [OP_W-1:0] va[3];
        logic [OP_W-1:0] vb[3];
        logic [OP_W:0]   ve[3];
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        ve[0] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
        va[1] = 64'h8000_0000_0000_0000; vb[1] = 64'h8000_0000_0000_0000;
        ve[1] = {1'b1, 64'h0};
        va[2] = 64'h0123_4567_89AB_CDEF; vb[2] = 64'h1111_1111_1111_1111;
        ve[2] = {1'b0, 64'h1234_5678_9ABC_DF00};
        in_valid = 1'b1;
        cin      = 1'b0;
        for (int k = 0; k < 3; k++) begin
          a = va[k];
          b = vb[k];
          exp_q.push_back(ve[k]);
          wait_in_ready("t5");
          t_acc[k] = cyc;
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int guard = 0;
        while (got < 3 && guard < 100) begin
          @(negedge clk);
          guard++;
          if (out_valid) begin
            if (exp_q.size() > 0) begin
              check_eq("t5_result", {cout, sum}, exp_q.pop_front());
            end
            got++;
          end
        end
      end
    join
    out_ready = 1'b0;
    check_eq("t5_count", 65'(got),               65'(3));
    check_eq("t5_ii_0",  65'(t_acc[1] - t_acc[0]), 65'(6));
    check_eq("t5_ii_1",  65'(t_acc[2] - t_acc[1]), 65'(6));
    @(negedge clk);

`ifdef CSA_SEQ_SUB_EN
    // T6: subtraction; cin is ignored when sub=1.
    sub = 1'b1;
    offer("t6a", 64'h5, 64'h7, 1'b0);
    wait_out_valid(lat);
    check_eq("t6a_sum",  65'(sum),  65'h0_FFFF_FFFF_FFFF_FFFE);
    check_eq("t6a_cout", 65'(cout), 65'(0));
    take_result();
    offer("t6b", 64'h7, 64'h5, 1'b0);
    wait_out_valid(lat);
    check_eq("t6b_sum",  65'(sum),  65'h2);
    check_eq("t6b_cout", 65'(cout), 65'(1));
    take_result();
    sub = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/csa_wide_add_seq.md
# csa_wide_add_seq

Multi-cycle sequencer that performs WORDS×16-bit addition by time-multiplexing a single 16-bit carry-select adder. Each cycle it feeds one 16-bit operand slice to the adder, lowest word first, and chains the carry through a register. It presents a valid/ready handshake on both sides. It sits between the operand source (register file or bus master) and any consumer of wide sums. It replaces a WORDS-wide combinational adder where area matters more than latency.

## Interface
- WORDS, 4: number of 16-bit slices. Legal range is 1–16; operand width is 16*WORDS.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set offered
- in_ready  out  1  sequencer can accept; high only in IDLE
- a  in  16*WORDS  operand A
- b  in  16*WORDS  operand B
- cin  in  1  carry into word 0
- sub  in  1  subtract request; present only when CSA_SEQ_SUB_EN is defined
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  16*WORDS  result
- cout  out  1  carry out of the top word
- busy  out  1  high in RUN or DONE

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: one slice per cycle, index idx from 0 to WORDS-1.
  - DONE: out_valid=1.
- IDLE→RUN on in_valid&&in_ready.
  - Capture a, b into operand registers.
  - Load carry register with cin (or the subtract carry, see Configuration).
  - Set idx=0.
  - Input changes after capture are ignored.
- RUN, each cycle:
  - Adder inputs are op_a[idx], op_b[idx] and the carry register.
  - On the edge: sum[idx] ← adder sum, carry ← adder cout, idx ← idx+1.
  - When idx==WORDS-1 at the edge: go to DONE and load cout ← adder cout.
- DONE: sum and cout held stable. On out_valid&&out_ready go to IDLE.
- in_valid in RUN/DONE is not accepted; the source holds it.
- Arithmetic: modular over 16*WORDS bits; cout is the true carry out. No overflow flag.
- sum is not cleared on return to IDLE; it holds the last result until slices are overwritten.
- idx width is clog2(WORDS) with a minimum of 1. It never wraps past WORDS-1.
- WORDS=1: RUN lasts exactly one cycle.

## Timing
- Reset values (asynchronous, applied immediately):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - sum=0, cout=0, idx=0, carry register=0.
- Reset mid-RUN or mid-DONE aborts the operation. Partial sum is cleared and no result is emitted.
- Latency: out_valid rises WORDS cycles after the accept edge.
- Minimum initiation interval is WORDS+2 cycles with in_valid and out_ready held high: accept, WORDS RUN edges, DONE handshake, then IDLE accept.
- Backpressure: out_valid, sum and cout stay stable while out_ready=0. There is no timeout.
- All outputs are registered except in_ready and out_valid, which are decoded from the state register.

## Configuration
- CSA_SEQ_SUB_EN defined:
  - The sub port exists and is captured with the operands.
  - When sub=1, each op_b slice is inverted before the adder and the initial carry is forced to 1 (cin ignored). Result is a−b.
  - cout=1 means no borrow.
- CSA_SEQ_SUB_EN undefined:
  - The sub port and inversion logic are absent.
  - The initial carry is always cin.

## Structure
- Shared package holds:
  - WORD_W=16.
  - The state enum (IDLE, RUN, DONE).
  - The WORDS legal-range constants.
- Sub-module: one instance of Carry_Select_Adder_16bits (ports a, b, cin, sum, cout) as the slice adder. No other hierarchy.

## Test plan
- WORDS=4, a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 → sum=0, cout=1, out_valid exactly 4 cycles after accept.
- WORDS=4, a=0x0000_0000_0000_FCFF, b=0x0000_0000_0000_FFF0, cin=1 → sum=0x0000_0000_0001_FCF0, cout=0 (carry chained into word 1).
- out_ready held low 5 cycles in DONE while in_valid=1 with new operands → sum/cout/out_valid stable, in_ready=0, new operands not captured until after the handshake.
- rst_n pulsed low after 2 RUN cycles → out_valid=0, sum=0, in_ready=1 immediately. A following op a=1, b=2 gives sum=3.
- in_valid and out_ready tied high, three ops back-to-back → accepts spaced exactly 6 cycles, all results correct.
- With CSA_SEQ_SUB_EN: a=5, b=7, sub=1 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. a=7, b=5, sub=1 → sum=2, cout=1.
